// File: rtl/tl_pkg.sv
// Shared lamp encodings, approach indices and the code-legality helper
// used by the traffic light monitor and its per-approach checkers.
package tl_pkg;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int IDX_M1 = 0;
    localparam int IDX_S  = 1;
    localparam int IDX_MT = 2;
    localparam int IDX_M2 = 3;

    localparam int NUM_APPR = 4;

    function automatic logic is_legal(input logic [2:0] code);
        return (code == RED) || (code == YEL) || (code == GRN);
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp bus between the traffic light controller (master) and anything
// that observes its four lamp outputs (slave).
interface traffic_light_monitor_if;

    logic [2:0] light_M1;
    logic [2:0] light_S;
    logic [2:0] light_MT;
    logic [2:0] light_M2;

    modport master (
        output light_M1,
        output light_S,
        output light_MT,
        output light_M2
    );

    modport slave (
        input light_M1,
        input light_S,
        input light_MT,
        input light_M2
    );

endinterface

// File: rtl/tl_lamp_checker.sv
// Per-approach checker: tracks the last legal colour and how long it has
// been held, and emits single-cycle violation pulses for the current sample.
module tl_lamp_checker
    import tl_pkg::*;
#(
    parameter int YELLOW_CYC = 3,
    parameter int MIN_GREEN  = 5,
    parameter int DUR_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    output logic       illegal,
    output logic       seq,
    output logic       timing,
    output logic       non_red
);

    localparam logic [DUR_W-1:0] YEL_LEN = DUR_W'(YELLOW_CYC);
    localparam logic [DUR_W-1:0] GRN_MIN = DUR_W'(MIN_GREEN);

    logic [2:0]       prev_q, prev_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             legal_code;
    logic             legal_step;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q <= RED;
            dur_q  <= '0;
        end else begin
            prev_q <= prev_d;
            dur_q  <= dur_d;
        end
    end

    always_comb begin
        prev_d     = prev_q;
        dur_d      = dur_q;
        illegal    = 1'b0;
        seq        = 1'b0;
        timing     = 1'b0;
        legal_code = is_legal(light);
        legal_step = ((prev_q == GRN) && (light == YEL)) ||
                     ((prev_q == YEL) && (light == RED)) ||
                     ((prev_q == RED) && (light == GRN));

        // An illegal code leaves history untouched so the next legal
        // colour is judged against the last legal one.
        if (!legal_code) begin
            illegal = 1'b1;
        end else if (light == prev_q) begin
            if (dur_q != '1) begin
                dur_d = dur_q + 1'b1;
            end
        end else begin
            seq = !legal_step;
            if ((prev_q == YEL) && (dur_q != YEL_LEN)) begin
                timing = 1'b1;
            end
            if ((prev_q == GRN) && (light == YEL) && (dur_q < GRN_MIN)) begin
                timing = 1'b1;
            end
            prev_d = light;
            dur_d  = DUR_W'(1);
        end

        non_red = legal_code && (light != RED);
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety monitor on the four lamp buses: per-approach checks,
// cross-approach conflict detection, sticky flags and a saturating error count.
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int YELLOW_CYC = 3,
    parameter int MIN_GREEN  = 5,
    parameter int DUR_W      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_err,
    traffic_light_monitor_if.slave   lamp_bus,
    output logic [NUM_APPR-1:0]      err_illegal,
    output logic [NUM_APPR-1:0]      err_seq,
    output logic [NUM_APPR-1:0]      err_timing,
    output logic                     err_conflict,
    output logic                     err_any,
    output logic [CNT_W-1:0]         err_count
);

    logic [2:0]          lamp [NUM_APPR];
    logic [NUM_APPR-1:0] new_illegal, new_seq, new_timing, non_red;
    logic                new_conflict;
    logic                new_viol;

    logic [NUM_APPR-1:0] illegal_q, illegal_d;
    logic [NUM_APPR-1:0] seq_q, seq_d;
    logic [NUM_APPR-1:0] timing_q, timing_d;
    logic                conflict_q, conflict_d;
    logic                any_q, any_d;
    logic [CNT_W-1:0]    count_q, count_d;

    assign lamp[IDX_M1] = lamp_bus.light_M1;
    assign lamp[IDX_S]  = lamp_bus.light_S;
    assign lamp[IDX_MT] = lamp_bus.light_MT;
    assign lamp[IDX_M2] = lamp_bus.light_M2;

    for (genvar i = 0; i < NUM_APPR; i++) begin : g_appr
        tl_lamp_checker #(
            .YELLOW_CYC (YELLOW_CYC),
            .MIN_GREEN  (MIN_GREEN),
            .DUR_W      (DUR_W)
        ) u_chk (
            .clk     (clk),
            .rst     (rst),
            .light   (lamp[i]),
            .illegal (new_illegal[i]),
            .seq     (new_seq[i]),
            .timing  (new_timing[i]),
            .non_red (non_red[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            illegal_q  <= '0;
            seq_q      <= '0;
            timing_q   <= '0;
            conflict_q <= 1'b0;
            any_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            illegal_q  <= illegal_d;
            seq_q      <= seq_d;
            timing_q   <= timing_d;
            conflict_q <= conflict_d;
            any_q      <= any_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        // M1 may run with M2 or MT; the side road must run alone and the
        // turn lane must not cross M2.
        new_conflict = (non_red[IDX_S] &&
                        (non_red[IDX_M1] || non_red[IDX_M2] || non_red[IDX_MT])) ||
                       (non_red[IDX_MT] && non_red[IDX_M2]);
        new_viol = (|new_illegal) || (|new_seq) || (|new_timing) || new_conflict;

        illegal_d  = illegal_q | new_illegal;
        seq_d      = seq_q | new_seq;
        timing_d   = timing_q | new_timing;
        conflict_d = conflict_q | new_conflict;
        count_d    = count_q;

        if (clr_err) begin
            illegal_d  = new_illegal;
            seq_d      = new_seq;
            timing_d   = new_timing;
            conflict_d = new_conflict;
            count_d    = new_viol ? CNT_W'(1) : '0;
        end else if (new_viol && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end

        any_d = (|illegal_d) || (|seq_d) || (|timing_d) || conflict_d;
    end

    assign err_illegal  = illegal_q;
    assign err_seq      = seq_q;
    assign err_timing   = timing_q;
    assign err_conflict = conflict_q;
    assign err_any      = any_q;
    assign err_count    = count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with YELLOW_CYC=3, MIN_GREEN=5.
module tb_traffic_light_monitor;
    import tl_pkg::*;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             clr_err;
    logic [3:0]       err_illegal;
    logic [3:0]       err_seq;
    logic [3:0]       err_timing;
    logic             err_conflict;
    logic             err_any;
    logic [CNT_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    traffic_light_monitor_if lamp_bus ();

    traffic_light_monitor #(
        .YELLOW_CYC (3),
        .MIN_GREEN  (5),
        .DUR_W      (8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr_err      (clr_err),
        .lamp_bus     (lamp_bus.slave),
        .err_illegal  (err_illegal),
        .err_seq      (err_seq),
        .err_timing   (err_timing),
        .err_conflict (err_conflict),
        .err_any      (err_any),
        .err_count    (err_count)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_all(input logic [2:0] m1, input logic [2:0] s,
                           input logic [2:0] mt, input logic [2:0] m2);
        lamp_bus.light_M1 = m1;
        lamp_bus.light_S  = s;
        lamp_bus.light_MT = mt;
        lamp_bus.light_M2 = m2;
    endtask

    task automatic settle_clear();
        set_all(RED, RED, RED, RED);
        step(1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
    endtask

    task automatic check_clean(input string name);
        checks++;
        if ({err_illegal, err_seq, err_timing, err_conflict, err_any, err_count} !== '0) begin
            errors++;
            $display("FAIL %s: ill=%b seq=%b tim=%b conf=%b any=%b cnt=%0d, required all zero",
                     name, err_illegal, err_seq, err_timing, err_conflict, err_any, err_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clr_err = 1'b0;
        set_all(RED, 3'b111, RED, RED);
        step(2);
        check_clean("reset_outputs");
        set_all(RED, RED, RED, RED);
        step(1);
        check_clean("reset_hold");
    endtask

    task automatic test_clean_cycle();
        rst = 1'b1;
        step(3);
        check_clean("all_red");
        lamp_bus.light_M1 = GRN;
        step(6);
        check_clean("m1_green6");
        lamp_bus.light_M1 = YEL;
        step(3);
        check_clean("m1_yellow3");
        lamp_bus.light_M1 = RED;
        step(1);
        check_clean("m1_back_red");
        // exact minimum green is still legal
        lamp_bus.light_M1 = GRN;
        step(5);
        lamp_bus.light_M1 = YEL;
        step(3);
        lamp_bus.light_M1 = RED;
        step(1);
        check_clean("m1_min_green");
    endtask

    task automatic test_skip_yellow();
        lamp_bus.light_M1 = GRN;
        step(6);
        checks++;
        if (err_seq !== 4'b0000) begin
            errors++;
            $display("FAIL skip_pre_seq: got %b want 0000", err_seq);
        end
        lamp_bus.light_M1 = RED;
        step(1);
        checks++;
        if (err_seq !== 4'b0001) begin
            errors++;
            $display("FAIL skip_seq: got %b want 0001", err_seq);
        end
        checks++;
        if (err_count !== 16'd1 || err_any !== 1'b1) begin
            errors++;
            $display("FAIL skip_count: cnt=%0d any=%b want 1 1", err_count, err_any);
        end
        checks++;
        if (err_timing !== 4'b0000) begin
            errors++;
            $display("FAIL skip_timing: got %b want 0000", err_timing);
        end
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check_clean("skip_cleared");
    endtask

    task automatic test_yellow_long();
        lamp_bus.light_M2 = GRN;
        step(6);
        lamp_bus.light_M2 = YEL;
        step(4);
        checks++;
        if (err_timing !== 4'b0000) begin
            errors++;
            $display("FAIL ylong_pre: got %b want 0000", err_timing);
        end
        lamp_bus.light_M2 = RED;
        step(1);
        checks++;
        if (err_timing !== 4'b1000 || err_seq !== 4'b0000) begin
            errors++;
            $display("FAIL ylong_flag: tim=%b seq=%b want 1000 0000", err_timing, err_seq);
        end
        checks++;
        if (err_count !== 16'd1) begin
            errors++;
            $display("FAIL ylong_count: got %0d want 1", err_count);
        end
        settle_clear();
        check_clean("ylong_cleared");
    endtask

    task automatic test_short_green();
        lamp_bus.light_M1 = GRN;
        step(4);
        lamp_bus.light_M1 = YEL;
        step(1);
        checks++;
        if (err_timing !== 4'b0001 || err_seq !== 4'b0000 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL short_green: tim=%b seq=%b cnt=%0d want 0001 0000 1",
                     err_timing, err_seq, err_count);
        end
        step(2);
        lamp_bus.light_M1 = RED;
        step(1);
        checks++;
        if (err_timing !== 4'b0001 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL short_green_hold: tim=%b cnt=%0d want 0001 1", err_timing, err_count);
        end
        settle_clear();
        check_clean("short_cleared");
    endtask

    task automatic test_conflict();
        set_all(RED, GRN, RED, YEL);
        step(1);
        checks++;
        if (err_conflict !== 1'b1 || err_count !== 16'd1 || err_any !== 1'b1) begin
            errors++;
            $display("FAIL conflict_s_m2: conf=%b cnt=%0d any=%b want 1 1 1",
                     err_conflict, err_count, err_any);
        end
        settle_clear();
        check_clean("conflict_cleared");
        set_all(GRN, RED, RED, GRN);
        step(1);
        check_clean("m1_m2_ok");
        step(5);
        set_all(YEL, RED, RED, YEL);
        step(3);
        set_all(RED, RED, RED, RED);
        step(1);
        check_clean("m1_m2_cycle");
    endtask

    task automatic test_illegal();
        lamp_bus.light_MT = 3'b011;
        step(2);
        checks++;
        if (err_illegal !== 4'b0100 || err_count !== 16'd2) begin
            errors++;
            $display("FAIL illegal_mt: ill=%b cnt=%0d want 0100 2", err_illegal, err_count);
        end
        lamp_bus.light_MT = GRN;
        step(1);
        checks++;
        if (err_seq !== 4'b0000 || err_conflict !== 1'b0 || err_count !== 16'd2) begin
            errors++;
            $display("FAIL illegal_then_grn: seq=%b conf=%b cnt=%0d want 0000 0 2",
                     err_seq, err_conflict, err_count);
        end
        settle_clear();
        check_clean("illegal_cleared");
    endtask

    task automatic test_clr_priority();
        lamp_bus.light_M1 = GRN;
        step(1);
        lamp_bus.light_M1 = RED;
        step(1);
        checks++;
        if (err_seq !== 4'b0001 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL clrp_setup: seq=%b cnt=%0d want 0001 1", err_seq, err_count);
        end
        lamp_bus.light_S = 3'b111;
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        checks++;
        if (err_illegal !== 4'b0010 || err_seq !== 4'b0000 ||
            err_count !== 16'd1 || err_any !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_viol: ill=%b seq=%b cnt=%0d any=%b want 0010 0000 1 1",
                     err_illegal, err_seq, err_count, err_any);
        end
        rst = 1'b0;
        step(1);
        check_clean("mid_reset");
        rst = 1'b1;
        set_all(RED, RED, RED, RED);
        step(1);
        check_clean("after_reset");
    endtask

    initial begin
        test_reset();
        test_clean_cycle();
        test_skip_yellow();
        test_yellow_long();
        test_short_green();
        test_conflict();
        test_illegal();
        test_clr_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
